// File: rtl/noc_credit_tx_if.sv
// noc_credit_tx_if: link bundle for the credit-based NoC transmitter.
//   Source side : in_valid/in_ready handshake with in_data/in_dest/in_is_tail.
//   Router side : data_out/dest_out/is_tail_out qualified by send_out,
//                 credit_in pulses returned by the downstream buffer.
//   master modport : the transmitter's view.
//   slave modport  : the view of whatever drives the source and the credit
//                    return (a bench, or source + router glue).
interface noc_credit_tx_if #(
  parameter int FLIT_WIDTH = 128,
  parameter int DEST_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [FLIT_WIDTH-1:0] in_data;
  logic [DEST_WIDTH-1:0] in_dest;
  logic                  in_is_tail;
  logic [FLIT_WIDTH-1:0] data_out;
  logic [DEST_WIDTH-1:0] dest_out;
  logic                  is_tail_out;
  logic                  send_out;
  logic                  credit_in;

  modport master (
    input  in_valid, in_data, in_dest, in_is_tail, credit_in,
    output in_ready, data_out, dest_out, is_tail_out, send_out
  );

  modport slave (
    output in_valid, in_data, in_dest, in_is_tail, credit_in,
    input  in_ready, data_out, dest_out, is_tail_out, send_out
  );
endinterface

// File: rtl/noc_credit_tx.sv
// noc_credit_tx: sending end of a credit-based router link.
// Flits from a valid/ready source go into a 2-entry FIFO. The head is popped
// into the output registers whenever a downstream credit is available, and
// send_out pulses one cycle later. Returned credit_in pulses replenish the
// credit count.
// Ports:
//   clk_noc, rst_noc_sync : clock, synchronous active-high reset
//   link (master)         : source handshake, router link, credit return
//   credits_avail         : current credit count
//   flit_count, pkt_count : flits / tail flits sent (wrapping)
//   stall_count           : cycles with a flit waiting and no credit (saturating)
//   credit_overflow       : sticky, a credit arrived while already at full count
module noc_credit_tx #(
  parameter int FLIT_WIDTH        = 128,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc_sync,
  noc_credit_tx_if.master         link,
  output logic [CREDIT_WIDTH-1:0] credits_avail,
  output logic [31:0]             flit_count,
  output logic [31:0]             pkt_count,
  output logic [31:0]             stall_count,
  output logic                    credit_overflow
);

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
  } flit_t;

  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = CREDIT_WIDTH'(1);

  flit_t                   mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    push;
  logic                    pop;
  logic                    stall;
  logic                    nonempty;
  flit_t                   in_flit;
  flit_t                   head;

  // in_ready depends only on the registered occupancy, so there is no
  // combinational path from in_valid back to in_ready.
  assign link.in_ready = (count != 2'd2);

  assign nonempty = (count != 2'd0);
  assign push     = link.in_valid & link.in_ready;
  assign pop      = nonempty & (credits != '0);
  assign stall    = nonempty & (credits == '0);

  assign in_flit  = '{data: link.in_data, dest: link.in_dest, is_tail: link.in_is_tail};
  assign head     = mem[rd_ptr];

  assign credits_avail = credits;

  // Storage is not reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clk_noc) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A pop consumes one credit and a returned credit adds one; both together
  // cancel. A credit with nothing outstanding is a protocol error: hold at
  // max and flag it.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      credits         <= CRED_MAX;
      credit_overflow <= 1'b0;
    end else begin
      case ({pop, link.credit_in})
        2'b10: credits <= credits - CRED_ONE;
        2'b01: begin
          if (credits == CRED_MAX) credit_overflow <= 1'b1;
          else                     credits         <= credits + CRED_ONE;
        end
        default: credits <= credits;
      endcase
    end
  end

  // Output registers hold the last flit sent; send_out qualifies them.
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      link.send_out    <= 1'b0;
      link.data_out    <= '0;
      link.dest_out    <= '0;
      link.is_tail_out <= 1'b0;
    end else begin
      link.send_out <= pop;
      if (pop) begin
        link.data_out    <= head.data;
        link.dest_out    <= head.dest;
        link.is_tail_out <= head.is_tail;
      end
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      flit_count  <= '0;
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (pop)                 flit_count  <= flit_count + 32'd1;
      if (pop && head.is_tail) pkt_count   <= pkt_count + 32'd1;
      if (stall && (stall_count != '1)) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_noc_credit_tx.sv
module tb_noc_credit_tx;
  localparam int FW = 128;
  localparam int DW = 4;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] credits_avail;
  logic [31:0]   flit_count, pkt_count, stall_count;
  logic          credit_overflow;

  noc_credit_tx_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW)) link ();

  noc_credit_tx #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)) dut (
    .clk_noc(clk), .rst_noc_sync(rst), .link(link),
    .credits_avail(credits_avail), .flit_count(flit_count), .pkt_count(pkt_count),
    .stall_count(stall_count), .credit_overflow(credit_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] d;
    logic [DW-1:0] dest;
    logic          t;
  } flit_t;

  typedef struct {
    logic          v;
    logic [FW-1:0] d;
    logic [DW-1:0] dest;
    logic          t;
    logic          crd;
    logic          e_send;
    logic [FW-1:0] e_d;
    logic [DW-1:0] e_dest;
    logic          e_t;
    int            e_cred;
    logic          e_rdy;
  } vec_t;

  int    n_checks = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    n_sent = 0;
  int    n_tail = 0;
  int    crd_given = 0;
  bit    loopback = 0;
  logic [3:0] lb = '0;
  flit_t exp_q[$];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Credits the link should hold: full depth minus flits sent plus credits returned.
  function automatic int crd_model();
    return DEPTH - n_sent + crd_given;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    link.in_valid = 1'b0;
    link.credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n_sent = 0; n_tail = 0; crd_given = 0; lb = '0;
  endtask

  // One clock: record accepted flit/credit, advance, then score any send.
  task automatic step();
    flit_t f;
    if (link.in_valid && link.in_ready)
      exp_q.push_back('{d: link.in_data, dest: link.in_dest, t: link.in_is_tail});
    if (link.credit_in) crd_given++;
    @(posedge clk);
    #1;
    cyc++;
    if (link.send_out) begin
      n_sent++;
      if (link.is_tail_out) n_tail++;
      if (exp_q.size() == 0) begin
        chk("send_without_flit", 1, 0);
      end else begin
        f = exp_q.pop_front();
        chk("order_data", link.data_out, f.d);
        chk("order_dest", FW'(link.dest_out), FW'(f.dest));
        chk("order_tail", FW'(link.is_tail_out), FW'(f.t));
      end
    end
    if (loopback) begin
      lb = {lb[2:0], link.send_out};
      link.credit_in = lb[3];
    end
  endtask

  vec_t vecs[11];

  initial begin
    int idx, first, last;
    logic [31:0] s0;
    bit acc;

    link.in_valid = 0; link.in_data = '0; link.in_dest = '0;
    link.in_is_tail = 0; link.credit_in = 0;

    // ---- reset state ----
    do_reset();
    chk("rst_ready", FW'(link.in_ready), 1);
    chk("rst_send", FW'(link.send_out), 0);
    chk("rst_data", link.data_out, 0);
    chk("rst_credits", FW'(credits_avail), DEPTH);
    chk("rst_flit", flit_count, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_ovf", FW'(credit_overflow), 0);

    // ---- table: single flit, then simultaneous pop + credit + push ----
    //          v  data    dest t  crd  send e_data  dest t  cred rdy
    vecs[0]  = '{1, 'hA5, 3, 1, 0,   0, 'h0,   0, 0, 8, 1};
    vecs[1]  = '{0, 'h0,  0, 0, 0,   1, 'hA5,  3, 1, 7, 1};
    vecs[2]  = '{0, 'h0,  0, 0, 0,   0, 'hA5,  3, 1, 7, 1};
    vecs[3]  = '{1, 'hB0, 1, 0, 0,   0, 'hA5,  3, 1, 7, 1};
    vecs[4]  = '{1, 'hB1, 2, 0, 0,   1, 'hB0,  1, 0, 6, 1};
    vecs[5]  = '{1, 'hB2, 3, 0, 0,   1, 'hB1,  2, 0, 5, 1};
    vecs[6]  = '{1, 'hB3, 4, 1, 0,   1, 'hB2,  3, 0, 4, 1};
    vecs[7]  = '{1, 'hB4, 5, 0, 0,   1, 'hB3,  4, 1, 3, 1};
    vecs[8]  = '{1, 'hB5, 6, 1, 1,   1, 'hB4,  5, 0, 3, 1};
    vecs[9]  = '{0, 'h0,  0, 0, 0,   1, 'hB5,  6, 1, 2, 1};
    vecs[10] = '{0, 'h0,  0, 0, 0,   0, 'hB5,  6, 1, 2, 1};
    for (int i = 0; i < 11; i++) begin
      link.in_valid = vecs[i].v; link.in_data = vecs[i].d;
      link.in_dest = vecs[i].dest; link.in_is_tail = vecs[i].t;
      link.credit_in = vecs[i].crd;
      step();
      chk($sformatf("vec%0d_send", i), FW'(link.send_out), FW'(vecs[i].e_send));
      chk($sformatf("vec%0d_data", i), link.data_out, vecs[i].e_d);
      chk($sformatf("vec%0d_dest", i), FW'(link.dest_out), FW'(vecs[i].e_dest));
      chk($sformatf("vec%0d_tail", i), FW'(link.is_tail_out), FW'(vecs[i].e_t));
      chk($sformatf("vec%0d_cred", i), FW'(credits_avail), FW'(vecs[i].e_cred));
      chk($sformatf("vec%0d_rdy", i), FW'(link.in_ready), FW'(vecs[i].e_rdy));
    end
    link.credit_in = 0;
    chk("tbl_flit", flit_count, 7);
    chk("tbl_pkt", pkt_count, 3);
    chk("tbl_stall", stall_count, 0);

    // ---- credit exhaustion ----
    do_reset();
    idx = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      link.in_valid = (idx < 11); link.in_data = FW'(32'h100 + idx);
      link.in_dest = DW'(idx); link.in_is_tail = 0;
      acc = link.in_valid && link.in_ready;
      step();
      if (acc) idx++;
      if (link.send_out) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    chk("exh_sends", n_sent, 8);
    chk("exh_consecutive", last - first, 7);
    chk("exh_credits", FW'(credits_avail), 0);
    chk("exh_ready", FW'(link.in_ready), 0);
    chk("exh_accepted", idx, 10);
    s0 = stall_count;
    repeat (5) step();
    chk("exh_stall_inc", stall_count - s0, 5);
    chk("exh_no_send", n_sent, 8);
    link.credit_in = 1;
    step();
    link.credit_in = 0;
    chk("exh_c1_send", FW'(link.send_out), 0);
    chk("exh_c1_cred", FW'(credits_avail), 1);
    step();
    chk("exh_c2_send", FW'(link.send_out), 1);
    chk("exh_c2_data", link.data_out, 'h108);
    repeat (3) step();
    chk("exh_one_more", n_sent, 9);
    link.in_valid = 0;

    // ---- credit overflow ----
    do_reset();
    link.credit_in = 1;
    step();
    link.credit_in = 0;
    chk("ovf_cred", FW'(credits_avail), DEPTH);
    chk("ovf_flag", FW'(credit_overflow), 1);
    repeat (4) step();
    chk("ovf_sticky", FW'(credit_overflow), 1);
    do_reset();
    chk("ovf_cleared", FW'(credit_overflow), 0);

    // ---- streaming with 4-cycle credit loopback ----
    loopback = 1;
    idx = 0; first = -1; last = -1;
    for (int c = 0; c < 400 && n_sent < 100; c++) begin
      link.in_valid = (idx < 100); link.in_data = FW'(idx * 32'h1001);
      link.in_dest = DW'(idx); link.in_is_tail = (idx % 4 == 3);
      acc = link.in_valid && link.in_ready;
      step();
      if (acc) idx++;
      if (link.send_out) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    link.in_valid = 0;
    chk("str_sends", n_sent, 100);
    chk("str_rate", last - first, 99);
    chk("str_flit", flit_count, 100);
    chk("str_pkt", pkt_count, 25);
    chk("str_stall", stall_count, 0);
    repeat (8) step();
    chk("str_cred_back", FW'(credits_avail), DEPTH);
    loopback = 0;
    link.credit_in = 0;

    // ---- randomized traffic against the scoreboard ----
    do_reset();
    for (int c = 0; c < 400; c++) begin
      link.in_valid = 1'($urandom_range(0, 1));
      link.in_data = {$urandom, $urandom, $urandom, $urandom};
      link.in_dest = DW'($urandom);
      link.in_is_tail = 1'($urandom_range(0, 1));
      link.credit_in = (crd_model() < DEPTH) && ($urandom_range(0, 2) != 0);
      step();
      chk("rnd_cred", FW'(credits_avail), FW'(crd_model()));
    end
    link.in_valid = 0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      link.credit_in = (crd_model() < DEPTH);
      step();
    end
    link.credit_in = 0;
    repeat (2) step();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_flit", flit_count, n_sent);
    chk("rnd_pkt", pkt_count, n_tail);
    chk("rnd_ovf", FW'(credit_overflow), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
